// File: rtl/param_updown_counter.sv
// Parametrised up/down counter with load, wrap/saturate modes and cascade flags.
// Q and ovf are registered; tc is a combinational carry-enable for the next stage.
module param_updown_counter #(
    parameter int unsigned WIDTH    = 3,
    parameter int unsigned MODULUS  = 1 << WIDTH,
    parameter int unsigned SATURATE = 0
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] Q,
    output logic             tc,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);
    localparam logic             SAT     = (SATURATE != 0);

    logic             at_max;
    logic             at_zero;
    logic [WIDTH-1:0] q_next;
    logic             ovf_next;

    assign at_max  = (Q == MAX_VAL);
    assign at_zero = (Q == '0);

    assign tc = en & ((up_dn & at_max) | (~up_dn & at_zero));

    // Next-state: load > count > hold; a boundary count raises ovf for one cycle.
    always_comb begin
        q_next   = Q;
        ovf_next = 1'b0;
        if (load) begin
            q_next = ({1'b0, load_val} >= MOD_EXT) ? MAX_VAL : load_val;
        end else if (en) begin
            if (up_dn) begin
                if (at_max) begin
                    ovf_next = 1'b1;
                    q_next   = SAT ? Q : '0;
                end else begin
                    q_next = Q + WIDTH'(1);
                end
            end else begin
                if (at_zero) begin
                    ovf_next = 1'b1;
                    q_next   = SAT ? Q : MAX_VAL;
                end else begin
                    q_next = Q - WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            Q   <= '0;
            ovf <= 1'b0;
        end else begin
            Q   <= q_next;
            ovf <= ovf_next;
        end
    end

endmodule

// File: tb/tb_param_updown_counter.sv
// Bench for param_updown_counter: three parameter variants driven in parallel,
// checked by a vector table, hand sequences and a randomized reference model.
module tb_param_updown_counter;

    logic       clk = 1'b0;
    logic       clear, en, up_dn, load;
    logic [2:0] load_val;

    logic [2:0] q_def, q_m6, q_sat;
    logic       tc_def, tc_m6, tc_sat;
    logic       ovf_def, ovf_m6, ovf_sat;

    param_updown_counter #(.WIDTH(3), .MODULUS(8), .SATURATE(0)) u_def (
        .clk(clk), .clear(clear), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .Q(q_def), .tc(tc_def), .ovf(ovf_def));
    param_updown_counter #(.WIDTH(3), .MODULUS(6), .SATURATE(0)) u_m6 (
        .clk(clk), .clear(clear), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .Q(q_m6), .tc(tc_m6), .ovf(ovf_m6));
    param_updown_counter #(.WIDTH(3), .MODULUS(8), .SATURATE(1)) u_sat (
        .clk(clk), .clear(clear), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .Q(q_sat), .tc(tc_sat), .ovf(ovf_sat));

    always #10 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state per instance: 0=default, 1=modulus 6, 2=saturating
    int mod_p [3] = '{8, 6, 8};
    int sat_p [3] = '{0, 0, 1};
    int mq    [3] = '{0, 0, 0};
    int movf  [3] = '{0, 0, 0};

    typedef struct {
        logic       en;
        logic       up_dn;
        logic       load;
        logic [2:0] lv;
        int         q;
        int         ovf;
        int         tc;
    } vec_t;

    vec_t tbl [17];

    function automatic int dut_q(int i);
        case (i)
            0:       return int'(q_def);
            1:       return int'(q_m6);
            default: return int'(q_sat);
        endcase
    endfunction

    function automatic int dut_ovf(int i);
        case (i)
            0:       return int'(ovf_def);
            1:       return int'(ovf_m6);
            default: return int'(ovf_sat);
        endcase
    endfunction

    function automatic int dut_tc(int i);
        case (i)
            0:       return int'(tc_def);
            1:       return int'(tc_m6);
            default: return int'(tc_sat);
        endcase
    endfunction

    function automatic int model_tc(int i);
        if (!en) return 0;
        if (up_dn) return (mq[i] == mod_p[i] - 1) ? 1 : 0;
        return (mq[i] == 0) ? 1 : 0;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic check_model(input string tag);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s q[%0d]", tag, i), dut_q(i), mq[i]);
            chk($sformatf("%s ovf[%0d]", tag, i), dut_ovf(i), movf[i]);
            chk($sformatf("%s tc[%0d]", tag, i), dut_tc(i), model_tc(i));
        end
    endtask

    // Advance one rising edge, updating the model from the held inputs.
    task automatic step();
        int nq [3];
        int no [3];
        for (int i = 0; i < 3; i++) begin
            nq[i] = mq[i];
            no[i] = 0;
            if (clear) begin
                nq[i] = 0;
            end else if (load) begin
                nq[i] = (int'(load_val) >= mod_p[i]) ? mod_p[i] - 1 : int'(load_val);
            end else if (en) begin
                if (up_dn) begin
                    if (mq[i] == mod_p[i] - 1) begin
                        no[i] = 1;
                        nq[i] = sat_p[i] ? mq[i] : 0;
                    end else begin
                        nq[i] = mq[i] + 1;
                    end
                end else begin
                    if (mq[i] == 0) begin
                        no[i] = 1;
                        nq[i] = sat_p[i] ? mq[i] : mod_p[i] - 1;
                    end else begin
                        nq[i] = mq[i] - 1;
                    end
                end
            end
        end
        @(posedge clk);
        #1;
        mq   = nq;
        movf = no;
    endtask

    task automatic drive(input logic e, input logic u, input logic l, input logic [2:0] v);
        en = e; up_dn = u; load = l; load_val = v;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        drive(1'b0, 1'b1, 1'b0, 3'd0);
        step();
        clear = 1'b0;
    endtask

    initial begin
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 3'd0, 1, 0, 0};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 3'd0, 2, 0, 0};
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 3'd0, 3, 0, 0};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 3'd0, 4, 0, 0};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 3'd0, 5, 0, 0};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 3'd0, 6, 0, 0};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 3'd0, 7, 0, 1};
        tbl[7]  = '{1'b1, 1'b1, 1'b0, 3'd0, 0, 1, 0};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 3'd0, 7, 1, 0};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 3'd0, 6, 0, 0};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 3'd0, 5, 0, 0};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 3'd0, 4, 0, 0};
        tbl[12] = '{1'b1, 1'b1, 1'b1, 3'd3, 3, 0, 0};
        tbl[13] = '{1'b1, 1'b1, 1'b0, 3'd0, 4, 0, 0};
        tbl[14] = '{1'b0, 1'b1, 1'b0, 3'd0, 4, 0, 0};
        tbl[15] = '{1'b1, 1'b0, 1'b1, 3'd0, 0, 0, 1};
        tbl[16] = '{1'b1, 1'b0, 1'b0, 3'd0, 7, 1, 0};

        clear = 1'b1;
        drive(1'b0, 1'b1, 1'b0, 3'd0);
        #5;
        chk("reset q", int'(q_def), 0);
        chk("reset ovf", int'(ovf_def), 0);
        step();
        clear = 1'b0;

        // Vector table on the default instance, other instances against the model
        foreach (tbl[k]) begin
            drive(tbl[k].en, tbl[k].up_dn, tbl[k].load, tbl[k].lv);
            step();
            chk($sformatf("vec%0d q", k), int'(q_def), tbl[k].q);
            chk($sformatf("vec%0d ovf", k), int'(ovf_def), tbl[k].ovf);
            chk($sformatf("vec%0d tc", k), int'(tc_def), tbl[k].tc);
            check_model($sformatf("vec%0d", k));
        end

        // Asynchronous clear between edges, held with en=1
        drive(1'b0, 1'b1, 1'b1, 3'd5);
        step();
        chk("preclear q", int'(q_def), 5);
        drive(1'b0, 1'b1, 1'b0, 3'd0);
        #5;
        clear = 1'b1;
        #2;
        chk("async clear q", int'(q_def), 0);
        chk("async clear ovf", int'(ovf_def), 0);
        mq = '{0, 0, 0};
        movf = '{0, 0, 0};
        drive(1'b1, 1'b1, 1'b1, 3'd6);
        step();
        step();
        chk("clear held q", int'(q_def), 0);
        check_model("clear held");
        clear = 1'b0;

        // Modulus 6: wrap after 5 and clamp an out-of-range load
        pulse_clear();
        for (int k = 1; k <= 6; k++) begin
            drive(1'b1, 1'b1, 1'b0, 3'd0);
            step();
            chk($sformatf("m6 up%0d q", k), int'(q_m6), k % 6);
        end
        chk("m6 wrap ovf", int'(ovf_m6), 1);
        drive(1'b0, 1'b1, 1'b1, 3'd7);
        step();
        chk("m6 load clamp q", int'(q_m6), 5);
        chk("def load 7 q", int'(q_def), 7);
        check_model("m6");

        // Saturating instance: hold at 7 with ovf, then step down
        pulse_clear();
        for (int k = 0; k < 7; k++) begin
            drive(1'b1, 1'b1, 1'b0, 3'd0);
            step();
        end
        chk("sat reach q", int'(q_sat), 7);
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("sat hold%0d q", k), int'(q_sat), 7);
            chk($sformatf("sat hold%0d ovf", k), int'(ovf_sat), 1);
        end
        drive(1'b1, 1'b0, 1'b0, 3'd0);
        step();
        chk("sat down q", int'(q_sat), 6);
        chk("sat down ovf", int'(ovf_sat), 0);
        check_model("sat");

        // Randomized stimulus against the reference model
        for (int k = 0; k < 400; k++) begin
            clear = ($urandom_range(0, 24) == 0);
            drive(1'(($urandom_range(0, 3) != 0)), 1'($urandom_range(0, 1)),
                  1'(($urandom_range(0, 7) == 0)), 3'($urandom_range(0, 7)));
            step();
            check_model($sformatf("rnd%0d", k));
        end
        clear = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
